// File: rtl/stepper_move_ctrl_if.sv
// ============================================================================
//  Module   : stepper_move_ctrl_if
//  Purpose  : Move-command valid/ready channel between host and sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface stepper_move_ctrl_if #(
  parameter int W = 16
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_dir;
  logic [W-1:0] cmd_steps;
  logic [W-1:0] cmd_period;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_steps,
    output cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_steps,
    input  cmd_period,
    output cmd_ready
  );
endinterface

`default_nettype wire

// File: rtl/stepper_move_ctrl.sv
// ============================================================================
//  Module   : stepper_move_ctrl
//  Purpose  : Stepper move sequencer: dir/step/mo pin timing and position.
//             Optional encoder stall detection when STALL_DETECT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stepper_move_ctrl #(
  parameter int         W         = 16,
  parameter logic [1:0] MODE      = 2'b01,
  parameter int         STEP_HI   = 4,
  parameter int         DIR_SETUP = 8,
  parameter int         STALL_WIN = 16
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  stepper_move_ctrl_if.slave cmd,
  input  wire logic          abort,
  input  wire logic          enc_tick,
  output logic [1:0]         mo,
  output logic               dir,
  output logic               step,
  output logic               busy,
  output logic               done,
  output logic               stall,
  output logic [W-1:0]       pos
);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_SETUP = 2'd1;
  localparam logic [1:0] C_HIGH  = 2'd2;
  localparam logic [1:0] C_LOW   = 2'd3;

  localparam logic [W-1:0] C_SETUP_LD = W'(DIR_SETUP - 1);
  localparam logic [W-1:0] C_HI_LD    = W'(STEP_HI - 1);
  localparam logic [W-1:0] C_MIN_PER  = W'(STEP_HI + 1);

  logic [1:0]   r_state;
  logic [W-1:0] r_cnt;
  logic [W-1:0] r_remaining;
  logic [W-1:0] r_low_ld;
  logic         r_dir;
  logic [W-1:0] r_pos;
  logic         r_done;
  logic         r_abort_pend;

  logic         w_accept;
  logic [W-1:0] w_eff_period;
  logic         w_step_rise;
  logic         w_stall_hit;

  assign w_accept     = cmd.cmd_valid && (r_state == C_IDLE);
  assign w_eff_period = (cmd.cmd_period < C_MIN_PER) ? C_MIN_PER : cmd.cmd_period;

  // A LOW phase that sees abort ends the move instead of raising another pulse.
  assign w_step_rise = ((r_state == C_SETUP) && (r_cnt == '0) && !abort) ||
                       ((r_state == C_LOW) && (r_cnt == '0) && !abort &&
                        (r_remaining != '0));

`ifdef STALL_DETECT_EN
  localparam int MW = $clog2(STALL_WIN + 1);

  logic [MW-1:0] r_miss;
  logic          r_stall;

  assign w_stall_hit = w_step_rise && !enc_tick && (r_miss == MW'(STALL_WIN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss  <= '0;
      r_stall <= 1'b0;
    end else begin
      if (w_accept || enc_tick) begin
        r_miss <= '0;
      end else if (w_step_rise) begin
        r_miss <= r_miss + 1'b1;
      end
      if (w_accept && (cmd.cmd_steps != '0)) begin
        r_stall <= 1'b0;
      end else if (w_stall_hit) begin
        r_stall <= 1'b1;
      end
    end
  end

  assign stall = r_stall;
`else
  logic w_unused_enc;

  assign w_unused_enc = enc_tick;
  assign w_stall_hit  = 1'b0;
  assign stall        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= C_IDLE;
      r_cnt        <= '0;
      r_remaining  <= '0;
      r_low_ld     <= '0;
      r_dir        <= 1'b0;
      r_pos        <= '0;
      r_done       <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_step_rise) begin
        // pos and remaining move on the same edge that raises step
        r_state      <= C_HIGH;
        r_cnt        <= C_HI_LD;
        r_remaining  <= r_remaining - 1'b1;
        r_pos        <= r_dir ? (r_pos + 1'b1) : (r_pos - 1'b1);
        r_abort_pend <= w_stall_hit;
      end else begin
        case (r_state)
          C_IDLE: begin
            if (w_accept) begin
              if (cmd.cmd_steps == '0) begin
                r_done <= 1'b1;
              end else begin
                r_dir        <= cmd.cmd_dir;
                r_remaining  <= cmd.cmd_steps;
                r_low_ld     <= w_eff_period - C_MIN_PER;
                r_cnt        <= C_SETUP_LD;
                r_abort_pend <= 1'b0;
                r_state      <= C_SETUP;
              end
            end
          end
          C_SETUP, C_LOW: begin
            if (abort || (r_cnt == '0)) begin
              r_state <= C_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          C_HIGH: begin
            // abort inside a pulse is remembered so the pulse keeps full width
            if (abort) begin
              r_abort_pend <= 1'b1;
            end
            if (r_cnt == '0) begin
              if (r_abort_pend || abort) begin
                r_state <= C_IDLE;
                r_done  <= 1'b1;
              end else begin
                r_state <= C_LOW;
                r_cnt   <= r_low_ld;
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: r_state <= C_IDLE;
        endcase
      end
    end
  end

  assign mo            = MODE;
  assign dir           = r_dir;
  assign step          = (r_state == C_HIGH);
  assign busy          = (r_state != C_IDLE);
  assign done          = r_done;
  assign pos           = r_pos;
  assign cmd.cmd_ready = (r_state == C_IDLE);

endmodule

`default_nettype wire
